// File: rtl/alu_pkg.sv
// Shared constants and FSM encoding for the ALU arbiter and its ALU.
package alu_pkg;

  localparam int DATA_WIDTH = 4;
  localparam int OP_WIDTH   = 2;

  localparam logic [OP_WIDTH-1:0] ADD_OP = 2'b00;
  localparam logic [OP_WIDTH-1:0] SUB_OP = 2'b01;
  localparam logic [OP_WIDTH-1:0] OR_OP  = 2'b10;
  localparam logic [OP_WIDTH-1:0] AND_OP = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/alu.sv
// Combinational 4-bit ALU; arithmetic wraps modulo 2^DATA_WIDTH with no carry or borrow out.
module alu
  import alu_pkg::*;
(
  input  logic [OP_WIDTH-1:0]   operation_i,
  input  logic [DATA_WIDTH-1:0] operand1_i,
  input  logic [DATA_WIDTH-1:0] operand2_i,
  output logic [DATA_WIDTH-1:0] result_o
);

  always_comb begin
    result_o = '0;
    case (operation_i)
      ADD_OP:  result_o = operand1_i + operand2_i;
      SUB_OP:  result_o = operand1_i - operand2_i;
      OR_OP:   result_o = operand1_i | operand2_i;
      AND_OP:  result_o = operand1_i & operand2_i;
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU between two requesters: accept one op, execute, return the
// registered result to its owner. Only req*_ready_o is combinational from the inputs.
module alu_arbiter
  import alu_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req0_valid_i,
  output logic                  req0_ready_o,
  input  logic [OP_WIDTH-1:0]   req0_operation_i,
  input  logic [DATA_WIDTH-1:0] req0_operand1_i,
  input  logic [DATA_WIDTH-1:0] req0_operand2_i,
  output logic                  rsp0_valid_o,
  input  logic                  rsp0_ready_i,
  output logic [DATA_WIDTH-1:0] rsp0_result_o,
  input  logic                  req1_valid_i,
  output logic                  req1_ready_o,
  input  logic [OP_WIDTH-1:0]   req1_operation_i,
  input  logic [DATA_WIDTH-1:0] req1_operand1_i,
  input  logic [DATA_WIDTH-1:0] req1_operand2_i,
  output logic                  rsp1_valid_o,
  input  logic                  rsp1_ready_i,
  output logic [DATA_WIDTH-1:0] rsp1_result_o,
  output logic                  busy_o
);

  state_e                state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic                  owner_q, owner_d;
  logic [OP_WIDTH-1:0]   op_q, op_d;
  logic [DATA_WIDTH-1:0] opa_q, opa_d;
  logic [DATA_WIDTH-1:0] opb_q, opb_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic [DATA_WIDTH-1:0] alu_result;
  logic                  grant_valid;
  logic                  grant_idx;
  logic                  owner_rsp_ready;

  alu u_alu (
    .operation_i (op_q),
    .operand1_i  (opa_q),
    .operand2_i  (opb_q),
    .result_o    (alu_result)
  );

  // On a tie the requester not served last wins; a lone requester always wins.
  always_comb begin
    grant_valid = (state_q == IDLE) && (req0_valid_i || req1_valid_i);
    grant_idx   = 1'b0;
    if (!req0_valid_i) begin
      grant_idx = 1'b1;
    end else if (req1_valid_i) begin
      grant_idx = ~last_grant_q;
    end
    req0_ready_o = grant_valid && !grant_idx;
    req1_ready_o = grant_valid && grant_idx;
  end

  assign owner_rsp_ready = owner_q ? rsp1_ready_i : rsp0_ready_i;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    op_d         = op_q;
    opa_d        = opa_q;
    opb_d        = opb_q;
    result_d     = result_q;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          owner_d = grant_idx;
          op_d    = grant_idx ? req1_operation_i : req0_operation_i;
          opa_d   = grant_idx ? req1_operand1_i  : req0_operand1_i;
          opb_d   = grant_idx ? req1_operand2_i  : req0_operand2_i;
          state_d = EXEC;
        end
      end
      EXEC: begin
        result_d = alu_result;
        state_d  = RESP;
      end
      RESP: begin
        if (owner_rsp_ready) begin
          last_grant_d = owner_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      op_q         <= '0;
      opa_q        <= '0;
      opb_q        <= '0;
      result_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      op_q         <= op_d;
      opa_q        <= opa_d;
      opb_q        <= opb_d;
      result_q     <= result_d;
    end
  end

  // Response ports decode registered state only, so they never glitch with requester inputs.
  always_comb begin
    busy_o        = (state_q != IDLE);
    rsp0_valid_o  = (state_q == RESP) && !owner_q;
    rsp1_valid_o  = (state_q == RESP) && owner_q;
    rsp0_result_o = rsp0_valid_o ? result_q : '0;
    rsp1_result_o = rsp1_valid_o ? result_q : '0;
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed plus randomized checks of alu_arbiter against a transaction-level model of
// arbitration order, 3-cycle handshake timing and modulo-16 ALU arithmetic.
module tb_alu_arbiter;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_i;
  logic       req0_valid_i, req0_ready_o, rsp0_valid_o, rsp0_ready_i;
  logic       req1_valid_i, req1_ready_o, rsp1_valid_o, rsp1_ready_i;
  logic [1:0] req0_operation_i, req1_operation_i;
  logic [3:0] req0_operand1_i, req0_operand2_i, req1_operand1_i, req1_operand2_i;
  logic [3:0] rsp0_result_o, rsp1_result_o;
  logic       busy_o;

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .req0_valid_i     (req0_valid_i),
    .req0_ready_o     (req0_ready_o),
    .req0_operation_i (req0_operation_i),
    .req0_operand1_i  (req0_operand1_i),
    .req0_operand2_i  (req0_operand2_i),
    .rsp0_valid_o     (rsp0_valid_o),
    .rsp0_ready_i     (rsp0_ready_i),
    .rsp0_result_o    (rsp0_result_o),
    .req1_valid_i     (req1_valid_i),
    .req1_ready_o     (req1_ready_o),
    .req1_operation_i (req1_operation_i),
    .req1_operand1_i  (req1_operand1_i),
    .req1_operand2_i  (req1_operand2_i),
    .rsp1_valid_o     (rsp1_valid_o),
    .rsp1_ready_i     (rsp1_ready_i),
    .rsp1_result_o    (rsp1_result_o),
    .busy_o           (busy_o)
  );

  int vectors = 0;
  int miscompares = 0;

  // Model: pending request per requester, and which requester wins the next tie.
  int         prio;
  logic       m_v   [2];
  logic [1:0] m_op  [2];
  logic [3:0] m_a   [2];
  logic [3:0] m_b   [2];
  logic       m_rdy [2];
  int         left  [2];

  function automatic logic [3:0] refAlu(input int op, input int a, input int b);
    int r;
    case (op)
      0:       r = a + b;
      1:       r = a - b + 16;
      2:       r = a | b;
      default: r = a & b;
    endcase
    return 4'(r % 16);
  endfunction

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus();
    req0_valid_i     = m_v[0];
    req0_operation_i = m_op[0];
    req0_operand1_i  = m_a[0];
    req0_operand2_i  = m_b[0];
    rsp0_ready_i     = m_rdy[0];
    req1_valid_i     = m_v[1];
    req1_operation_i = m_op[1];
    req1_operand1_i  = m_a[1];
    req1_operand2_i  = m_b[1];
    rsp1_ready_i     = m_rdy[1];
  endtask

  task automatic setReq(input int r, input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    m_v[r]  = 1'b1;
    m_op[r] = op;
    m_a[r]  = a;
    m_b[r]  = b;
  endtask

  task automatic randReq(input int r);
    setReq(r, 2'($urandom_range(3, 0)), 4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)));
  endtask

  function automatic logic rspValid(input int r);
    return (r == 0) ? rsp0_valid_o : rsp1_valid_o;
  endfunction

  function automatic logic [3:0] rspResult(input int r);
    return (r == 0) ? rsp0_result_o : rsp1_result_o;
  endfunction

  task automatic checkAllQuiet(input string tag);
    checkOutput({tag, "_busy"}, 8'(busy_o), 8'd0);
    checkOutput({tag, "_rsp0_valid"}, 8'(rsp0_valid_o), 8'd0);
    checkOutput({tag, "_rsp1_valid"}, 8'(rsp1_valid_o), 8'd0);
    checkOutput({tag, "_rsp0_result"}, 8'(rsp0_result_o), 8'd0);
    checkOutput({tag, "_rsp1_result"}, 8'(rsp1_result_o), 8'd0);
    checkOutput({tag, "_req0_ready"}, 8'(req0_ready_o), 8'd0);
    checkOutput({tag, "_req1_ready"}, 8'(req1_ready_o), 8'd0);
  endtask

  // Called at a falling edge in IDLE with at least one model request pending; runs one
  // full accept/execute/respond transaction, with `hold` cycles of response backpressure.
  task automatic serveOne(input int hold);
    int         w;
    int         other;
    logic [3:0] exp_r;
    applyStimulus();
    #1;
    w     = (m_v[0] && m_v[1]) ? prio : (m_v[0] ? 0 : 1);
    other = 1 - w;
    exp_r = refAlu(int'(m_op[w]), int'(m_a[w]), int'(m_b[w]));
    checkOutput("idle_req0_ready", 8'(req0_ready_o), 8'(w == 0));
    checkOutput("idle_req1_ready", 8'(req1_ready_o), 8'(w == 1));
    checkOutput("idle_busy", 8'(busy_o), 8'd0);
    m_rdy[w] = (hold == 0);
    applyStimulus();
    @(negedge clk);
    if (left[w] > 0) begin
      left[w]--;
      randReq(w);
    end else begin
      m_v[w] = 1'b0;
    end
    applyStimulus();
    #1;
    checkOutput("exec_busy", 8'(busy_o), 8'd1);
    checkOutput("exec_req0_ready", 8'(req0_ready_o), 8'd0);
    checkOutput("exec_req1_ready", 8'(req1_ready_o), 8'd0);
    checkOutput("exec_rsp0_valid", 8'(rsp0_valid_o), 8'd0);
    checkOutput("exec_rsp1_valid", 8'(rsp1_valid_o), 8'd0);
    @(negedge clk);
    for (int i = 0; i <= hold; i++) begin
      if (i == hold) m_rdy[w] = 1'b1;
      applyStimulus();
      #1;
      checkOutput($sformatf("resp_owner%0d_valid", w), 8'(rspValid(w)), 8'd1);
      checkOutput($sformatf("resp_owner%0d_result", w), 8'(rspResult(w)), 8'(exp_r));
      checkOutput($sformatf("resp_other%0d_valid", other), 8'(rspValid(other)), 8'd0);
      checkOutput($sformatf("resp_other%0d_result", other), 8'(rspResult(other)), 8'd0);
      checkOutput("resp_busy", 8'(busy_o), 8'd1);
      checkOutput("resp_req0_ready", 8'(req0_ready_o), 8'd0);
      checkOutput("resp_req1_ready", 8'(req1_ready_o), 8'd0);
      @(negedge clk);
    end
    prio = other;
    #1;
    checkOutput("back_idle_busy", 8'(busy_o), 8'd0);
    checkOutput("back_idle_rsp_valid", 8'(rsp0_valid_o | rsp1_valid_o), 8'd0);
  endtask

  task automatic doReset();
    rst_i = 1'b1;
    m_v[0] = 1'b0;
    m_v[1] = 1'b0;
    applyStimulus();
    repeat (2) @(negedge clk);
    #1;
    checkAllQuiet("reset");
    rst_i = 1'b0;
    prio  = 0;
    @(negedge clk);
  endtask

  initial begin
    for (int r = 0; r < 2; r++) begin
      m_v[r] = 1'b0; m_op[r] = '0; m_a[r] = '0; m_b[r] = '0; m_rdy[r] = 1'b1; left[r] = 0;
    end
    prio = 0;
    applyStimulus();
    doReset();

    setReq(0, ADD_OP, 4'd4, 4'd7);
    serveOne(0);

    setReq(1, SUB_OP, 4'd4, 4'd7);
    serveOne(0);
    setReq(1, SUB_OP, 4'd13, 4'd7);
    serveOne(0);

    doReset();
    setReq(0, OR_OP, 4'd4, 4'd9);
    setReq(1, AND_OP, 4'd10, 4'd7);
    serveOne(0);
    serveOne(0);

    randReq(0);
    randReq(1);
    left[0] = 2;
    left[1] = 2;
    repeat (6) serveOne(0);

    randReq(0);
    serveOne(5);

    repeat (25) begin
      for (int r = 0; r < 2; r++) begin
        if (m_v[r] && $urandom_range(3, 0) == 0) m_v[r] = 1'b0;
        else if (!m_v[r] && $urandom_range(1, 0) == 1) randReq(r);
      end
      if (!m_v[0] && !m_v[1]) randReq(int'($urandom_range(1, 0)));
      serveOne(int'($urandom_range(2, 0)));
    end

    m_v[0] = 1'b0;
    m_v[1] = 1'b0;
    randReq(0);
    serveOne(0);
    setReq(1, ADD_OP, 4'd3, 4'd5);
    applyStimulus();
    #1;
    checkOutput("midrst_req1_ready", 8'(req1_ready_o), 8'd1);
    @(negedge clk);
    m_v[1] = 1'b0;
    rst_i  = 1'b1;
    applyStimulus();
    #1;
    checkOutput("midrst_exec_busy", 8'(busy_o), 8'd1);
    @(negedge clk);
    #1;
    checkAllQuiet("midrst_in_reset");
    rst_i = 1'b0;
    prio  = 0;
    repeat (3) begin
      @(negedge clk);
      #1;
      checkAllQuiet("midrst_after");
    end
    @(negedge clk);
    randReq(0);
    randReq(1);
    serveOne(0);
    serveOne(0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
